// File: rtl/fwd_hazard_tracker.sv
// fwd_hazard_tracker
//   Forwarding and load-use hazard unit beside the ID/EX boundary. Keeps a
//   private shift register of in-flight writer tags (entry[0] = ID/EX,
//   entry[k] = k-th stage after EX). It derives per-source forward selects
//   for the instruction in EX and a load-use stall for the instruction in ID.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   issue_valid         ID instruction wants to move to EX
//   issue_reg_write     ID instruction writes a register
//   issue_is_load       ID instruction is a load
//   issue_rd            ID destination register
//   issue_src           ID source registers, source i at [i*REG_BITS +: REG_BITS]
//   issue_src_used      per-source "operand is read" mask
//   flush               kill the ID instruction, bubble into ID/EX
//   stall               hold PC and IF/ID, bubble into ID/EX
//   fwd_sel             per EX source: 0 = register file, k = stage k result
//   stall_cycles        saturating count of stalled cycles
//   hazard_err          sticky: EX consumed a load result not yet forwardable
module fwd_hazard_tracker #(
    parameter int REG_BITS = 5,
    parameter int NUM_SRC  = 2,
    parameter int DEPTH    = 2,
    parameter int LOAD_LAT = 1,
    parameter int SELW     = $clog2(DEPTH + 1)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         issue_valid,
    input  logic                         issue_reg_write,
    input  logic                         issue_is_load,
    input  logic [REG_BITS-1:0]          issue_rd,
    input  logic [NUM_SRC*REG_BITS-1:0]  issue_src,
    input  logic [NUM_SRC-1:0]           issue_src_used,
    input  logic                         flush,
    output logic                         stall,
    output logic [NUM_SRC*SELW-1:0]      fwd_sel,
    output logic [15:0]                  stall_cycles,
    output logic                         hazard_err
);

    logic [DEPTH:0]          e_valid;
    logic [DEPTH:0]          e_wr;
    logic [DEPTH:0]          e_ld;
    logic [REG_BITS-1:0]     e_rd [0:DEPTH];
    logic [DEPTH:0]          writing;

    logic [NUM_SRC*REG_BITS-1:0] ex_src;
    logic [NUM_SRC-1:0]          ex_used;

    logic [NUM_SRC-1:0]      found;
    logic                    hz_now;
    logic                    accept;

    // Register 0 is hard-wired, so writers of r0 never create a dependency.
    always_comb begin
        writing = '0;
        for (int k = 0; k <= DEPTH; k++) begin
            writing[k] = e_valid[k] && e_wr[k] && (e_rd[k] != '0);
        end
    end

    // Load-use stall: a load still within its latency window (entries
    // 0..LOAD_LAT-1) cannot feed the ID instruction one cycle later.
    always_comb begin
        stall = 1'b0;
        if (issue_valid && !flush) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                for (int p = 0; p < LOAD_LAT; p++) begin
                    if (issue_src_used[i] && writing[p] && e_ld[p] &&
                        (e_rd[p] == issue_src[i*REG_BITS +: REG_BITS])) begin
                        stall = 1'b1;
                    end
                end
            end
        end
    end

    // Forward select: scan from the youngest stage so the most recent
    // writer of a register wins.
    always_comb begin
        fwd_sel = '0;
        found   = '0;
        hz_now  = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            for (int k = 1; k <= DEPTH; k++) begin
                if (!found[i] && ex_used[i] && writing[k] &&
                    (e_rd[k] == ex_src[i*REG_BITS +: REG_BITS])) begin
                    found[i]                 = 1'b1;
                    fwd_sel[i*SELW +: SELW]  = SELW'(k);
                    if (e_ld[k] && (k <= LOAD_LAT)) begin
                        hz_now = 1'b1;
                    end
                end
            end
        end
    end

    assign accept = issue_valid && !stall && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_valid      <= '0;
            e_wr         <= '0;
            e_ld         <= '0;
            for (int k = 0; k <= DEPTH; k++) begin
                e_rd[k] <= '0;
            end
            ex_src       <= '0;
            ex_used      <= '0;
            stall_cycles <= '0;
            hazard_err   <= 1'b0;
        end else begin
            // Back end never stalls: everything past ID/EX advances each cycle.
            for (int k = 1; k <= DEPTH; k++) begin
                e_valid[k] <= e_valid[k-1];
                e_wr[k]    <= e_wr[k-1];
                e_ld[k]    <= e_ld[k-1];
                e_rd[k]    <= e_rd[k-1];
            end
            if (accept) begin
                e_valid[0] <= 1'b1;
                e_wr[0]    <= issue_reg_write;
                e_ld[0]    <= issue_is_load;
                e_rd[0]    <= issue_rd;
                ex_src     <= issue_src;
                ex_used    <= issue_src_used;
            end else begin
                e_valid[0] <= 1'b0;
                e_wr[0]    <= 1'b0;
                e_ld[0]    <= 1'b0;
                e_rd[0]    <= '0;
                ex_used    <= '0;
            end
            if (stall && (stall_cycles != 16'hFFFF)) begin
                stall_cycles <= stall_cycles + 16'd1;
            end
            if (hz_now) begin
                hazard_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fwd_hazard_tracker.sv
module tb_fwd_hazard_tracker;

    logic        clk;
    logic        rst_n;

    // default-parameter instance
    logic        issue_valid, issue_reg_write, issue_is_load, flush;
    logic [4:0]  issue_rd;
    logic [9:0]  issue_src;
    logic [1:0]  issue_src_used;
    logic        stall;
    logic [3:0]  fwd_sel;
    logic [15:0] stall_cycles;
    logic        hazard_err;

    // long-latency instance used to reach counter saturation quickly
    logic        s_valid;
    logic        s_stall;
    logic [11:0] s_fwd_sel;
    logic [15:0] s_stall_cycles;
    logic        s_hazard_err;

    int vectors;
    int miscompares;

    fwd_hazard_tracker u_dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .issue_valid     (issue_valid),
        .issue_reg_write (issue_reg_write),
        .issue_is_load   (issue_is_load),
        .issue_rd        (issue_rd),
        .issue_src       (issue_src),
        .issue_src_used  (issue_src_used),
        .flush           (flush),
        .stall           (stall),
        .fwd_sel         (fwd_sel),
        .stall_cycles    (stall_cycles),
        .hazard_err      (hazard_err)
    );

    // load r6 <- [r6] held in ID forever: accepted once per 32 cycles,
    // stalled the other 31.
    fwd_hazard_tracker #(.DEPTH(32), .LOAD_LAT(31)) u_sat (
        .clk             (clk),
        .rst_n           (rst_n),
        .issue_valid     (s_valid),
        .issue_reg_write (1'b1),
        .issue_is_load   (1'b1),
        .issue_rd        (5'd6),
        .issue_src       (10'd6),
        .issue_src_used  (2'b01),
        .flush           (1'b0),
        .stall           (s_stall),
        .fwd_sel         (s_fwd_sel),
        .stall_cycles    (s_stall_cycles),
        .hazard_err      (s_hazard_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic drive(input logic v, input logic w, input logic l,
                         input logic [4:0] rd, input logic [4:0] s0,
                         input logic [4:0] s1, input logic [1:0] used,
                         input logic fl);
        issue_valid     = v;
        issue_reg_write = w;
        issue_is_load   = l;
        issue_rd        = rd;
        issue_src       = {s1, s0};
        issue_src_used  = used;
        flush           = fl;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b0);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        s_valid     = 1'b0;
        idle();
        #12;
        chk("rst_stall",   int'(stall),        0);
        chk("rst_fwd",     int'(fwd_sel),      0);
        chk("rst_cnt",     int'(stall_cycles), 0);
        chk("rst_err",     int'(hazard_err),   0);
        @(negedge clk);
        rst_n = 1'b1;
        next_cycle();
        next_cycle();

        // ALU rd=3, then two consumers of r3
        drive(1, 1, 0, 5'd3, 5'd0, 5'd0, 2'b00, 0);
        @(negedge clk); chk("alu_stall", int'(stall), 0);
        next_cycle();
        drive(1, 0, 0, 5'd0, 5'd3, 5'd0, 2'b01, 0);
        @(negedge clk); chk("cons1_stall", int'(stall), 0);
        next_cycle();
        drive(1, 0, 0, 5'd0, 5'd3, 5'd0, 2'b01, 0);
        @(negedge clk); chk("cons1_fwd", int'(fwd_sel), 4'b0001);
        next_cycle();
        idle();
        @(negedge clk); chk("cons2_fwd", int'(fwd_sel), 4'b0010);
        next_cycle();
        @(negedge clk); chk("bubble_fwd", int'(fwd_sel), 0);

        // load rd=4, dependent on src1
        next_cycle();
        drive(1, 1, 1, 5'd4, 5'd0, 5'd0, 2'b00, 0);
        @(negedge clk); chk("ld_stall", int'(stall), 0);
        next_cycle();
        drive(1, 0, 0, 5'd0, 5'd0, 5'd4, 2'b10, 0);
        @(negedge clk); chk("lu_stall1", int'(stall), 1);
        chk("lu_cnt0", int'(stall_cycles), 0);
        next_cycle();
        @(negedge clk); chk("lu_stall2", int'(stall), 0);
        next_cycle();
        idle();
        @(negedge clk); chk("lu_fwd", int'(fwd_sel), 4'b1000);
        chk("lu_cnt1", int'(stall_cycles), 1);
        chk("lu_err",  int'(hazard_err),   0);

        // same load, src1 not used
        next_cycle();
        drive(1, 1, 1, 5'd4, 5'd0, 5'd0, 2'b00, 0);
        next_cycle();
        drive(1, 0, 0, 5'd0, 5'd7, 5'd4, 2'b01, 0);
        @(negedge clk); chk("unused_stall", int'(stall), 0);
        next_cycle();
        idle();
        @(negedge clk); chk("unused_fwd", int'(fwd_sel), 0);
        chk("unused_cnt", int'(stall_cycles), 1);

        // rd=5 written twice, consumer reads r5 on both sources
        next_cycle();
        drive(1, 1, 0, 5'd5, 5'd0, 5'd0, 2'b00, 0);
        next_cycle();
        drive(1, 1, 0, 5'd5, 5'd0, 5'd0, 2'b00, 0);
        next_cycle();
        drive(1, 0, 0, 5'd0, 5'd5, 5'd5, 2'b11, 0);
        next_cycle();
        idle();
        @(negedge clk); chk("dual_fwd", int'(fwd_sel), 4'b0101);

        // writer of r0 never forwarded
        next_cycle();
        drive(1, 1, 0, 5'd0, 5'd0, 5'd0, 2'b00, 0);
        next_cycle();
        drive(1, 0, 0, 5'd0, 5'd0, 5'd0, 2'b01, 0);
        next_cycle();
        idle();
        @(negedge clk); chk("r0_fwd", int'(fwd_sel), 0);

        // load then flushed dependent
        next_cycle();
        drive(1, 1, 1, 5'd6, 5'd0, 5'd0, 2'b00, 0);
        next_cycle();
        drive(1, 0, 0, 5'd0, 5'd6, 5'd0, 2'b01, 1);
        @(negedge clk); chk("flush_stall", int'(stall), 0);
        next_cycle();
        idle();
        @(negedge clk); chk("flush_fwd", int'(fwd_sel), 0);
        chk("flush_cnt", int'(stall_cycles), 1);

        // reset in the middle of a stall
        next_cycle();
        drive(1, 1, 1, 5'd4, 5'd0, 5'd0, 2'b00, 0);
        next_cycle();
        drive(1, 0, 0, 5'd0, 5'd0, 5'd4, 2'b10, 0);
        @(negedge clk); chk("pre_rst_stall", int'(stall), 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_stall", int'(stall),        0);
        chk("mid_rst_fwd",   int'(fwd_sel),      0);
        chk("mid_rst_cnt",   int'(stall_cycles), 0);
        chk("mid_rst_err",   int'(hazard_err),   0);
        next_cycle();
        idle();
        rst_n = 1'b1;
        next_cycle();

        // saturation on the long-latency instance
        s_valid = 1'b1;
        @(negedge clk); chk("sat_c0_stall", int'(s_stall), 0);
        repeat (64) @(posedge clk);
        @(negedge clk);
        chk("sat_c64_cnt",   int'(s_stall_cycles), 62);
        chk("sat_c64_stall", int'(s_stall),        0);
        repeat (72500) @(posedge clk);
        @(negedge clk);
        chk("sat_cnt", int'(s_stall_cycles), 16'hFFFF);
        chk("sat_err", int'(s_hazard_err),   0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
